// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: start/ack handshake, operands, result.
// Optional ovf_o exists only when SERIAL_ADDER_OVERFLOW_EN is defined.
interface serial_adder_if #(
    parameter int N = 8
);
    logic         start_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         c_i;
    logic         ready_o;
    logic         valid_o;
    logic         ack_i;
    logic [N-1:0] sum_o;
    logic         c_o;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         ovf_o;

    modport slave  (input  start_i, a_i, b_i, c_i, ack_i,
                    output ready_o, valid_o, sum_o, c_o, ovf_o);
    modport master (output start_i, a_i, b_i, c_i, ack_i,
                    input  ready_o, valid_o, sum_o, c_o, ovf_o);
`else
    modport slave  (input  start_i, a_i, b_i, c_i, ack_i,
                    output ready_o, valid_o, sum_o, c_o);
    modport master (output start_i, a_i, b_i, c_i, ack_i,
                    input  ready_o, valid_o, sum_o, c_o);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder around one full_adder; optional signed-overflow flag via SERIAL_ADDER_OVERFLOW_EN.
// Latency: start in cycle 0, valid_o in cycle N+1; result held in DONE until ack_i.

// One-bit full adder.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic c_o
);
    assign s   = a ^ b ^ c;
    assign c_o = (a & b) | (c & (a ^ b));
endmodule

// LSB-first N-bit add of a_i + b_i + c_i, one bit per cycle.
// Latency: N+1 cycles from accepted start to valid_o.
// Backpressure: holds result in DONE while ack_i=0; start_i ignored unless ready_o.
module serial_adder #(
    parameter int N = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    serial_adder_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  s_reg;
    logic [N-1:0]  s_nxt;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          last;
    logic          fa_s;
    logic          fa_c;
    logic          ready;
    logic          valid;

    full_adder u_fa (
        .a   (a_reg[0]),
        .b   (b_reg[0]),
        .c   (carry),
        .s   (fa_s),
        .c_o (fa_c)
    );

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        valid     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.start_i) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                valid = 1'b1;
                if (bus.ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sum bit enters at the MSB so after N shifts bit 0 sits at the LSB.
    always_comb begin
        s_nxt        = s_reg >> 1;
        s_nxt[N-1]   = fa_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        a_reg <= bus.a_i;
                        b_reg <= bus.b_i;
                        carry <= bus.c_i;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    s_reg <= s_nxt;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf;

    // On the last bit, carry holds the carry into the MSB and fa_c the carry out.
    always_ff @(posedge clk_i) begin
        if (rst_i)                        ovf <= 1'b0;
        else if (state == SHIFT && last)  ovf <= carry ^ fa_c;
    end

    assign bus.ovf_o = ovf;
`endif

    assign bus.ready_o = ready;
    assign bus.valid_o = valid;
    assign bus.sum_o   = s_reg;
    assign bus.c_o     = carry;
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (N=8), immediate-assertion style.
module tb_serial_adder;
    localparam int N = 8;

    logic clk_i;
    logic rst_i;
    int   checks   = 0;
    int   failures = 0;
    int   lat;

    serial_adder_if #(.N(N)) bus ();

    serial_adder #(.N(N)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a start for one cycle, then counts cycles until valid_o (bounded).
    task automatic run_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                           output int n);
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.c_i     = c;
        tick();
        bus.start_i = 1'b0;
        n = 1;
        while (bus.valid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.c_i     = 1'b0;
        bus.ack_i   = 1'b1;
        tick();
        tick();
        check("rst_ready", bus.ready_o, 1);
        check("rst_valid", bus.valid_o, 0);
        check("rst_sum",   bus.sum_o,   0);
        check("rst_co",    bus.c_o,     0);
        rst_i = 1'b0;
        tick();

        // Basic add with ack held high
        run_add(8'h5A, 8'h3C, 1'b0, lat);
        check("lat_5a3c",   lat,         9);
        check("sum_5a3c",   bus.sum_o,   8'h96);
        check("co_5a3c",    bus.c_o,     0);
        tick();
        check("valid_1cyc", bus.valid_o, 0);
        check("ready_back", bus.ready_o, 1);
        check("sum_hold_idle", bus.sum_o, 8'h96);

        run_add(8'hFF, 8'h01, 1'b0, lat);
        check("sum_ff01", bus.sum_o, 8'h00);
        check("co_ff01",  bus.c_o,   1);
        tick();
        run_add(8'hFF, 8'hFF, 1'b1, lat);
        check("sum_ffff1", bus.sum_o, 8'hFF);
        check("co_ffff1",  bus.c_o,   1);
        tick();

        // Backpressure with an ignored start during DONE
        bus.ack_i = 1'b0;
        run_add(8'h12, 8'h34, 1'b0, lat);
        check("lat_bp", lat, 9);
        for (int i = 0; i < 5; i++) begin
            bus.start_i = (i == 2);
            bus.a_i     = 8'hAA;
            bus.b_i     = 8'h55;
            tick();
            bus.start_i = 1'b0;
            check("bp_valid", bus.valid_o, 1);
            check("bp_sum",   bus.sum_o,   8'h46);
            check("bp_co",    bus.c_o,     0);
        end
        bus.ack_i = 1'b1;
        tick();
        check("ack_valid", bus.valid_o, 0);
        check("ack_ready", bus.ready_o, 1);
        check("ack_sum",   bus.sum_o,   8'h46);

        // Start held during SHIFT must be ignored
        bus.start_i = 1'b1;
        bus.a_i     = 8'h81;
        bus.b_i     = 8'h90;
        bus.c_i     = 1'b1;
        tick();
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 50) begin
            bus.start_i = 1'b1;
            bus.a_i     = 8'(lat * 17);
            bus.b_i     = 8'(lat * 29);
            bus.c_i     = 1'b0;
            tick();
            lat++;
        end
        bus.start_i = 1'b0;
        check("lat_ign",  lat,       9);
        check("sum_ign",  bus.sum_o, 8'h12);
        check("co_ign",   bus.c_o,   1);
        tick();

        // Reset in the 4th SHIFT cycle
        bus.start_i = 1'b1;
        bus.a_i     = 8'hF0;
        bus.b_i     = 8'h0F;
        bus.c_i     = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        check("mid_rst_ready", bus.ready_o, 1);
        check("mid_rst_valid", bus.valid_o, 0);
        check("mid_rst_sum",   bus.sum_o,   0);
        check("mid_rst_co",    bus.c_o,     0);

        // Reset and start together: reset wins
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        rst_i       = 1'b0;
        tick();
        check("rst_start_ready", bus.ready_o, 1);

        run_add(8'h10, 8'h20, 1'b0, lat);
        check("lat_1020", lat,       9);
        check("sum_1020", bus.sum_o, 8'h30);
        check("co_1020",  bus.c_o,   0);
        tick();

`ifdef SERIAL_ADDER_OVERFLOW_EN
        run_add(8'h7F, 8'h01, 1'b0, lat);
        check("sum_7f01", bus.sum_o, 8'h80);
        check("ovf_7f01", bus.ovf_o, 1);
        check("co_7f01",  bus.c_o,   0);
        tick();
        run_add(8'hFF, 8'h01, 1'b0, lat);
        check("ovf_ff01", bus.ovf_o, 0);
        check("co_ff01b", bus.c_o,   1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
